// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

    localparam int PC_W  = 12;
    localparam int LUT_W = 5;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Decoder-side control and status bundle of the fetch sequencer.
interface fetch_ctrl_if #(
    parameter int D     = fetch_pkg::PC_W,
    parameter int LUT_W = fetch_pkg::LUT_W
);
    logic                   start;
    logic                   stall;
    logic                   halt;
    logic                   branch_en;
    logic                   branch_abs;
    logic [LUT_W-1:0]       branch_idx;
    logic                   lut_wr_en;
    logic [LUT_W-1:0]       lut_wr_addr;
    logic [D-1:0]           lut_wr_data;
    logic [D-1:0]           prog_ctr;
    logic                   running;
    logic                   done;
    logic [fetch_pkg::CNT_W-1:0] instr_count;

    // Decoder / host side.
    modport master (
        output start, stall, halt, branch_en, branch_abs, branch_idx,
        output lut_wr_en, lut_wr_addr, lut_wr_data,
        input  prog_ctr, running, done, instr_count
    );

    // Fetch sequencer side.
    modport slave (
        input  start, stall, halt, branch_en, branch_abs, branch_idx,
        input  lut_wr_en, lut_wr_addr, lut_wr_data,
        output prog_ctr, running, done, instr_count
    );
endinterface

// File: rtl/branch_lut.sv
// Branch-target table: register array, one synchronous write port and one
// combinational read port. No reset; contents persist across resets.
module branch_lut #(
    parameter int D     = fetch_pkg::PC_W,
    parameter int LUT_W = fetch_pkg::LUT_W
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [LUT_W-1:0] wr_addr,
    input  logic [D-1:0]     wr_data,
    input  logic [LUT_W-1:0] rd_addr,
    output logic [D-1:0]     rd_data
);
    localparam int ENTRIES = 2 ** LUT_W;

    logic [D-1:0] entry_reg [ENTRIES];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            // Each entry loads only when addressed by an enabled write.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == LUT_W'(gi))) begin
                    entry_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = entry_reg[rd_addr];

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer driving the instruction ROM address.
// RUN applies one action per cycle: halt > stall > branch > increment.
module fetch_ctrl #(
    parameter int D     = fetch_pkg::PC_W,
    parameter int LUT_W = fetch_pkg::LUT_W
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);
    import fetch_pkg::*;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_reg, state_next;
    logic [D-1:0]     pc_reg, pc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             lut_we;
    logic [D-1:0]     lut_target;
    logic [D-1:0]     rel_offset;

    // Table is only writable outside RUN so a branch read never races a write;
    // reset also blocks the write in its own edge.
    assign lut_we = bus.lut_wr_en && (state_reg != ST_RUN) && !reset;

    branch_lut #(
        .D     (D),
        .LUT_W (LUT_W)
    ) u_lut (
        .clk     (clk),
        .wr_en   (lut_we),
        .wr_addr (bus.lut_wr_addr),
        .wr_data (bus.lut_wr_data),
        .rd_addr (bus.branch_idx),
        .rd_data (lut_target)
    );

    assign rel_offset = {{(D-LUT_W){bus.branch_idx[LUT_W-1]}}, bus.branch_idx};

    // Next-state, PC mux and retired-instruction counter.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ST_RUN: begin
                if (bus.halt) begin
                    state_next = ST_DONE;
                    cnt_next   = sat_inc(cnt_reg);
                end else if (bus.stall) begin
                    pc_next = pc_reg;
                end else begin
                    cnt_next = sat_inc(cnt_reg);
                    if (bus.branch_en) begin
                        pc_next = bus.branch_abs ? lut_target : pc_reg + rel_offset;
                    end else begin
                        pc_next = pc_reg + D'(1);
                    end
                end
            end
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, PC and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.prog_ctr    = pc_reg;
    assign bus.running     = (state_reg == ST_RUN);
    assign bus.done        = (state_reg == ST_DONE);
    assign bus.instr_count = cnt_reg;

endmodule
